// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multi-cycle RISC-V datapath: register file, immediate generator, ALU and
//   data memory, sequenced IDLE -> DECODE -> EXEC -> (MEM) -> WB per Start.
//   Control inputs use the single-cycle decoder encoding unchanged.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   Start             instruction/control valid, sampled only in IDLE
//   RegWrite, ALUSrc, ALUControl, MemWrite, MemRead, MemToReg  control bundle
//   Instruction       RV32 instruction word
//   Busy              high in every state except IDLE
//   Done              one-cycle pulse in WB
//   Result            written-back value (ALU result for stores)
//   Sign, Zero        flags of the last ALU result
//   Trap              misaligned-access flag (only with the macro below)
//
// Build option
//   MULTICYCLE_DATAPATH_MISALIGN_TRAP_EN: misaligned load/store raises Trap,
//   skips MEM and suppresses the register write.

module multicycle_datapath #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned DMEM_DEPTH = 64
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic            RegWrite,
    input  logic            ALUSrc,
    input  logic [3:0]      ALUControl,
    input  logic            MemWrite,
    input  logic            MemRead,
    input  logic            MemToReg,
    input  logic [31:0]     Instruction,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic            Sign,
`ifdef MULTICYCLE_DATAPATH_MISALIGN_TRAP_EN
    output logic            Zero,
    output logic            Trap
`else
    output logic            Zero
`endif
);

    localparam int unsigned RegIdxW  = $clog2(REG_COUNT);
    localparam int unsigned MemIdxW  = $clog2(DMEM_DEPTH);
    localparam int unsigned ByteOffW = $clog2(XLEN / 8);
    localparam int unsigned ShamtW   = $clog2(XLEN);
    localparam logic [6:0]  OpcLui   = 7'b0110111;

    typedef enum logic [2:0] {StIdle, StDecode, StExec, StMem, StWb} state_e;

    state_e               state_q;
    logic [31:0]          instr_q;
    logic                 regwrite_q, alusrc_q, memwrite_q, memread_q, memtoreg_q;
    logic [3:0]           aluctl_q;
    logic [XLEN-1:0]      a_q, b_q, rs2_q;
    logic [MemIdxW-1:0]   mem_idx_q;
    logic                 busy_q, done_q, sign_q, zero_q;
    logic [XLEN-1:0]      result_q;
    logic [XLEN-1:0]      rf_q   [REG_COUNT];
    logic [XLEN-1:0]      dmem_q [DMEM_DEPTH];

    logic                 is_lui;
    logic [RegIdxW-1:0]   rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0]      rs1_val, rs2_val, imm, alu_res;
    logic [3:0]           alu_op;
    logic [ShamtW-1:0]    shamt;
    logic                 is_mem, wb_en;

    // Register indices wrap modulo REG_COUNT by dropping upper bits.
    assign is_lui  = (instr_q[6:0] == OpcLui);
    assign rs1_idx = instr_q[15 +: RegIdxW];
    assign rs2_idx = instr_q[20 +: RegIdxW];
    assign rd_idx  = instr_q[7 +: RegIdxW];
    assign rs1_val = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
    assign rs2_val = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
    assign alu_op  = is_lui ? 4'd0 : aluctl_q;
    assign shamt   = b_q[ShamtW-1:0];
    assign is_mem  = memread_q | memwrite_q;

    always_comb begin
        if (memwrite_q) begin
            imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
        end else if (is_lui) begin
            imm = {{(XLEN-31){instr_q[31]}}, instr_q[30:12], 12'b0};
        end else begin
            imm = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
        end
    end

    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = a_q + b_q;
            4'd1:    alu_res = a_q - b_q;
            4'd2:    alu_res = a_q & b_q;
            4'd3:    alu_res = a_q | b_q;
            4'd4:    alu_res = a_q << shamt;
            4'd5:    alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            4'd6:    alu_res = a_q ^ b_q;
            4'd7:    alu_res = a_q >> shamt;
            4'd8:    alu_res = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            default: alu_res = '0;
        endcase
    end

`ifdef MULTICYCLE_DATAPATH_MISALIGN_TRAP_EN
    logic trap_q;
    logic misaligned;
    assign misaligned = is_mem && (alu_res[ByteOffW-1:0] != '0);
    assign wb_en      = regwrite_q && (rd_idx != '0) && !trap_q;
    assign Trap       = trap_q;
`else
    assign wb_en      = regwrite_q && (rd_idx != '0);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            regwrite_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluctl_q   <= '0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memtoreg_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            rs2_q      <= '0;
            mem_idx_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
`ifdef MULTICYCLE_DATAPATH_MISALIGN_TRAP_EN
            trap_q     <= 1'b0;
`endif
            for (int i = 0; i < int'(REG_COUNT); i++) rf_q[i] <= '0;
            for (int i = 0; i < int'(DMEM_DEPTH); i++) dmem_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        instr_q    <= Instruction;
                        regwrite_q <= RegWrite;
                        alusrc_q   <= ALUSrc;
                        aluctl_q   <= ALUControl;
                        memwrite_q <= MemWrite;
                        memread_q  <= MemRead;
                        memtoreg_q <= MemToReg;
                        busy_q     <= 1'b1;
`ifdef MULTICYCLE_DATAPATH_MISALIGN_TRAP_EN
                        trap_q     <= 1'b0;
`endif
                        state_q    <= StDecode;
                    end
                end
                StDecode: begin
                    a_q     <= is_lui ? '0 : rs1_val;
                    b_q     <= alusrc_q ? imm : rs2_val;
                    rs2_q   <= rs2_val;
                    state_q <= StExec;
                end
                StExec: begin
                    result_q  <= alu_res;
                    sign_q    <= alu_res[XLEN-1];
                    zero_q    <= (alu_res == '0);
                    mem_idx_q <= alu_res[ByteOffW +: MemIdxW];
`ifdef MULTICYCLE_DATAPATH_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        trap_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StWb;
                    end else
`endif
                    if (is_mem) begin
                        state_q <= StMem;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    // A set MemWrite wins; the load side is then ignored.
                    if (memwrite_q) begin
                        dmem_q[mem_idx_q] <= rs2_q;
                    end else if (memtoreg_q) begin
                        result_q <= dmem_q[mem_idx_q];
                    end
                    done_q  <= 1'b1;
                    state_q <= StWb;
                end
                StWb: begin
                    if (wb_en) rf_q[rd_idx] <= result_q;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;
    assign Sign   = sign_q;
    assign Zero   = zero_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;

    logic        clk = 1'b0;
    logic        rst, start, regwrite, alusrc, memwrite, memread, memtoreg;
    logic [3:0]  aluctl;
    logic [31:0] instruction;
    logic        busy, done, sign, zero;
    logic [31:0] result;
    logic        trap_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    multicycle_datapath #(.XLEN(32), .REG_COUNT(32), .DMEM_DEPTH(64)) dut (
        .CLK(clk), .RST(rst), .Start(start), .RegWrite(regwrite), .ALUSrc(alusrc),
        .ALUControl(aluctl), .MemWrite(memwrite), .MemRead(memread), .MemToReg(memtoreg),
        .Instruction(instruction), .Busy(busy), .Done(done), .Result(result), .Sign(sign),
`ifdef MULTICYCLE_DATAPATH_MISALIGN_TRAP_EN
        .Zero(zero), .Trap(trap_w)
`else
        .Zero(zero)
`endif
    );
`ifndef MULTICYCLE_DATAPATH_MISALIGN_TRAP_EN
    assign trap_w = 1'b0;
`endif

    typedef struct {
        logic [31:0] ins;
        logic        rw, src;
        logic [3:0]  op;
        logic        mw, mr, m2r;
        logic [31:0] res;
        logic        sgn, zro;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [31:0] rf_m  [32];
    logic [31:0] mem_m [64];

    function automatic logic [31:0] enc_i(int imm, int rs1, int rd, logic [6:0] opc);
        return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], opc};
    endfunction
    function automatic logic [31:0] enc_r(int rs2, int rs1, int rd);
        return {7'b0, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd);
        return {imm20[19:0], rd[4:0], 7'h37};
    endfunction

    function automatic vec_t mk(logic [31:0] ins, logic rw, logic src, logic [3:0] op,
                                logic mw, logic mr, logic m2r, logic [31:0] res,
                                logic sgn, logic zro, int lat);
        vec_t v;
        v.ins = ins; v.rw = rw; v.src = src; v.op = op; v.mw = mw; v.mr = mr;
        v.m2r = m2r; v.res = res; v.sgn = sgn; v.zro = zro; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(input logic [31:0] ins, input logic rw, input logic src,
                       input logic [3:0] op, input logic mw, input logic mr, input logic m2r,
                       output int lat, output logic [31:0] res, output logic sgn,
                       output logic zro, output logic trp);
        @(negedge clk);
        instruction = ins; regwrite = rw; alusrc = src; aluctl = op;
        memwrite = mw; memread = mr; memtoreg = m2r; start = 1'b1;
        @(posedge clk);
        #1;
        // Garbage on the inputs after acceptance must not matter.
        start = 1'b0;
        instruction = $urandom; regwrite = 1'($urandom); alusrc = 1'($urandom);
        aluctl = 4'($urandom); memwrite = 1'($urandom); memread = 1'($urandom);
        memtoreg = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 20);
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL timeout: no Done after %0d cycles, expected Done", lat);
        end
        res = result; sgn = sign; zro = zero; trp = trap_w;
    endtask

    task automatic readreg(input int r, input logic [31:0] exp, input string name);
        int l; logic [31:0] v; logic s, z, t;
        run(enc_r(0, r, 0), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, l, v, s, z, t);
        check(name, v, exp);
    endtask

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a << b[4:0];
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a ^ b;
            4'd7: return a >> b[4:0];
            4'd8: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        int lat;
        logic [31:0] res;
        logic sgn, zro, trp;
        int ndone;

        instruction = '0; regwrite = 0; alusrc = 0; aluctl = '0;
        memwrite = 0; memread = 0; memtoreg = 0;
        do_reset();
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {29'b0, sign, zero, trap_w}, 32'd0);

        // ---- table-driven directed program ----
        vecs.push_back(mk(enc_i(20, 0, 2, 7'h13), 1, 1, 0, 0, 0, 0, 32'd20, 0, 0, 3));
        vecs.push_back(mk(enc_i(3, 0, 3, 7'h13), 1, 1, 0, 0, 0, 0, 32'd3, 0, 0, 3));
        vecs.push_back(mk(enc_r(3, 2, 4), 1, 0, 1, 0, 0, 0, 32'd17, 0, 0, 3));
        vecs.push_back(mk(enc_r(2, 3, 8), 1, 0, 5, 0, 0, 0, 32'd1, 0, 0, 3));
        vecs.push_back(mk(enc_r(3, 2, 7), 1, 0, 4, 0, 0, 0, 32'd160, 0, 0, 3));
        vecs.push_back(mk(enc_i(-1, 0, 1, 7'h13), 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 3));
        vecs.push_back(mk(enc_s(20, 1, 2), 0, 1, 0, 1, 0, 0, 32'd40, 0, 0, 4));
        vecs.push_back(mk(enc_i(20, 2, 14, 7'h03), 1, 1, 0, 0, 1, 1, 32'hFFFF_FFFF, 0, 0, 4));
        vecs.push_back(mk(enc_r(2, 1, 17), 1, 0, 8, 0, 0, 0, 32'd0, 0, 1, 3));
        vecs.push_back(mk(enc_r(2, 2, 0), 1, 0, 0, 0, 0, 0, 32'd40, 0, 0, 3));
        vecs.push_back(mk(enc_r(0, 0, 0), 0, 0, 0, 0, 0, 0, 32'd0, 0, 1, 3));
        vecs.push_back(mk(enc_r(2, 0, 11), 1, 0, 0, 0, 0, 0, 32'd20, 0, 0, 3));
        vecs.push_back(mk(enc_u(20, 22), 1, 1, 1, 0, 0, 0, 32'h0001_4000, 0, 0, 3));
        vecs.push_back(mk(enc_r(0, 14, 0), 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 3));
        vecs.push_back(mk(enc_r(0, 22, 0), 0, 0, 0, 0, 0, 0, 32'h0001_4000, 0, 0, 3));
        vecs.push_back(mk(enc_r(0, 4, 0), 0, 0, 0, 0, 0, 0, 32'd17, 0, 0, 3));
        vecs.push_back(mk(enc_r(0, 7, 0), 0, 0, 0, 0, 0, 0, 32'd160, 0, 0, 3));
        vecs.push_back(mk(enc_r(0, 8, 0), 0, 0, 0, 0, 0, 0, 32'd1, 0, 0, 3));
        vecs.push_back(mk(enc_r(0, 17, 0), 0, 0, 0, 0, 0, 0, 32'd0, 0, 1, 3));

        foreach (vecs[i]) begin
            run(vecs[i].ins, vecs[i].rw, vecs[i].src, vecs[i].op, vecs[i].mw, vecs[i].mr,
                vecs[i].m2r, lat, res, sgn, zro, trp);
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_sign", i), {31'b0, sgn}, {31'b0, vecs[i].sgn});
            check($sformatf("vec%0d_zero", i), {31'b0, zro}, {31'b0, vecs[i].zro});
        end

        // ---- Start held high while Busy: exactly one Done, second instr dropped ----
        @(negedge clk);
        instruction = enc_i(5, 0, 23, 7'h13); regwrite = 1; alusrc = 1; aluctl = 0;
        memwrite = 0; memread = 0; memtoreg = 0; start = 1'b1;
        @(posedge clk);
        #1 instruction = enc_i(7, 0, 24, 7'h13);
        ndone = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_after_start", {31'b0, busy}, 32'd1);
            if (done) ndone++;
            if (c == 4) start = 1'b0;
        end
        check("single_done", ndone, 1);
        readreg(23, 32'd5, "busy_x23");
        readreg(24, 32'd0, "busy_x24_ignored");

        // ---- RST during MEM of sw x1,20(x2) ----
        @(negedge clk);
        instruction = enc_s(20, 1, 2); regwrite = 0; alusrc = 1; aluctl = 0;
        memwrite = 1; memread = 0; memtoreg = 0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mem_busy", {31'b0, busy}, 32'd0);
        check("rst_mem_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        run(enc_i(20, 0, 2, 7'h13), 1, 1, 0, 0, 0, 0, lat, res, sgn, zro, trp);
        run(enc_i(20, 2, 14, 7'h03), 1, 1, 0, 0, 1, 1, lat, res, sgn, zro, trp);
        check("rst_mem_load", res, 32'd0);
        readreg(1, 32'd0, "rst_x1_cleared");

        // ---- misaligned store sw x5,21(x2) ----
        run(enc_i('h123, 0, 5, 7'h13), 1, 1, 0, 0, 0, 0, lat, res, sgn, zro, trp);
        run(enc_s(21, 5, 2), 0, 1, 0, 1, 0, 0, lat, res, sgn, zro, trp);
`ifdef MULTICYCLE_DATAPATH_MISALIGN_TRAP_EN
        check("misalign_lat", lat, 3);
        check("misalign_trap", {31'b0, trp}, 32'd1);
        @(negedge clk);
        check("misalign_trap_held", {31'b0, trap_w}, 32'd1);
        run(enc_i(20, 2, 6, 7'h03), 1, 1, 0, 0, 1, 1, lat, res, sgn, zro, trp);
        check("misalign_mem_unchanged", res, 32'd0);
        check("misalign_trap_cleared", {31'b0, trp}, 32'd0);
`else
        check("misalign_lat", lat, 4);
        run(enc_i(20, 2, 6, 7'h03), 1, 1, 0, 0, 1, 1, lat, res, sgn, zro, trp);
        check("misalign_word10", res, 32'h0000_0123);
`endif

        // ---- randomized run against the reference model ----
        do_reset();
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        for (int i = 0; i < 64; i++) mem_m[i] = '0;
        for (int n = 0; n < 300; n++) begin
            logic [31:0] ins, imm, a, b, alu, rs2v, wb, addr;
            logic rw, src, mw, mr, m2r, lui, etrap;
            logic [3:0] op, eop;
            int cls, elat;
            ins = $urandom;
            cls = $urandom_range(0, 4);
            op = 4'($urandom_range(0, 15));
            rw = 1'($urandom); src = 1'($urandom); mw = 0; mr = 0; m2r = 0;
            if (cls == 1) begin
                ins[6:0] = 7'b0110111; src = 1; rw = 1;
            end else begin
                if (ins[6:0] == 7'b0110111) ins[0] = 1'b0;
                if (cls == 2) begin
                    mw = 1; mr = 1'($urandom); op = 0; src = 1;
                end else if (cls == 3) begin
                    mr = 1; m2r = 1; rw = 1; op = 0; src = 1;
                end
            end
            lui  = (ins[6:0] == 7'b0110111);
            rs2v = rf_m[ins[24:20]];
            if (mw)       imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            else if (lui) imm = {ins[31:12], 12'b0};
            else          imm = {{20{ins[31]}}, ins[31:20]};
            a   = lui ? 32'd0 : rf_m[ins[19:15]];
            b   = src ? imm : rs2v;
            eop = lui ? 4'd0 : op;
            alu = ref_alu(eop, a, b);
            addr = alu;
            wb = alu;
            elat = (mw || mr) ? 4 : 3;
            etrap = 0;
`ifdef MULTICYCLE_DATAPATH_MISALIGN_TRAP_EN
            if ((mw || mr) && addr[1:0] != 2'b00) begin
                etrap = 1; elat = 3;
            end
`endif
            if (!etrap) begin
                if (mw) mem_m[(addr >> 2) % 64] = rs2v;
                else if (mr && m2r) wb = mem_m[(addr >> 2) % 64];
                if (rw && ins[11:7] != 5'd0) rf_m[ins[11:7]] = wb;
            end
            run(ins, rw, src, op, mw, mr, m2r, lat, res, sgn, zro, trp);
            check($sformatf("rnd%0d_result", n), res, wb);
            check($sformatf("rnd%0d_latency", n), lat, elat);
            check($sformatf("rnd%0d_sign", n), {31'b0, sgn}, {31'b0, alu[31]});
            check($sformatf("rnd%0d_zero", n), {31'b0, zro}, {31'b0, (alu == 32'd0)});
            check($sformatf("rnd%0d_trap", n), {31'b0, trp}, {31'b0, etrap});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
